host_bus_arbiter: RTL and testbench
===================================

# host_bus_arbiter

Round-robin arbiter that shares the single host-bus port of `simple_axi_master` between `NUM_REQ` requesters, such as instruction fetch, data load/store and DMA. Each requester sees the same host-bus protocol the master presents. The arbiter latches one request at a time and forwards it to the master. It returns the master's `done`, `rdata`, `invalid` and `error` to the granted requester only. When that requester acknowledges with `clear`, the arbiter clears the master and rotates priority.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 64: data width.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_addr`  in  NUM_REQ*ADDR_W  per-requester address; slice n is `[n*ADDR_W +: ADDR_W]`.
- `i_size`  in  NUM_REQ*3  per-requester transfer size (AXI size encoding).
- `i_wdata`  in  NUM_REQ*DATA_W  per-requester write data.
- `i_rw`  in  NUM_REQ*2  per-requester command: 00 none, 01 write, 10 read, 11 illegal (forwarded unchanged).
- `i_clear`  in  NUM_REQ  per-requester acknowledge of `o_done`.
- `o_rdata`  out  DATA_W  captured read data; shared by all requesters, meaningful to the granted one.
- `o_done`  out  NUM_REQ  per-requester transaction complete.
- `o_wait`  out  NUM_REQ  per-requester request pending, not yet done.
- `o_invalid`  out  NUM_REQ  per-requester captured invalid flag from the master.
- `o_error`  out  NUM_REQ  per-requester captured error flag from the master.
- `o_grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `o_m_addr`  out  ADDR_W  to master `i_addr`.
- `o_m_size`  out  3  to master `i_size`.
- `o_m_wdata`  out  DATA_W  to master `i_wdata`.
- `o_m_rw`  out  2  to master `i_rw`.
- `o_m_clear`  out  1  to master `i_clear`.
- `i_m_rdata`  in  DATA_W  from master `o_rdata`.
- `i_m_wait`  in  1  from master `o_wait`; observed only, no decision depends on it.
- `i_m_done`  in  1  from master `o_done`; sticky until the master is cleared.
- `i_m_invalid`  in  1  from master `o_invalid`.
- `i_m_error`  in  1  from master `o_error`.

## Operation
- **Requester contract:**
  - Drive `rw` nonzero and hold `addr`, `size` and `wdata` until `o_done`.
  - Then drive `rw` to 00 and pulse `clear` for at least one cycle.
- **State machine:** four states, IDLE, ISSUE, RESP and CLEAR, held in registers.
- **IDLE:**
  - Pointer `ptr` (ceil(log2 NUM_REQ) bits) selects the starting position.
  - The first requester with `rw != 00`, searching from `ptr` upward and wrapping modulo NUM_REQ, becomes the grant `g`.
  - Its `addr`, `size`, `wdata` and `rw` are latched into registers, and the state goes to ISSUE.
  - `i_clear` has no effect in IDLE.
- **ISSUE:**
  - `o_m_*` are driven from the latched registers; `o_m_rw` = latched `rw`.
  - On a cycle where `i_m_done` is 1: capture `i_m_rdata`, `i_m_invalid` and `i_m_error`, then go to RESP.
  - Requester input changes, including `rw` dropping to 00, are ignored. The latched request completes regardless.
  - `i_clear` is ignored; there is no abort.
- **RESP:**
  - `o_m_rw` = 00.
  - `o_done[g]` = 1; `o_invalid[g]` and `o_error[g]` show the captured flags.
  - When `i_clear[g]` is 1: go to CLEAR and set `ptr` = (g+1) mod NUM_REQ.
  - `i_clear` from a requester other than `g` is ignored.
  - There is no timeout: the arbiter stays in RESP until `g` clears.
- **CLEAR:**
  - `o_m_clear` = 1 for exactly one cycle, then go to IDLE.
  - The master must drop `i_m_done` on that same edge.
- **Other outputs:**
  - `o_wait[n]` is combinational: `(i_rw[n] != 00) && !(state == RESP && g == n)`.
  - `o_grant` = one-hot(g) in ISSUE, RESP and CLEAR; 0 in IDLE.
  - `o_done`, `o_invalid` and `o_error` are 0 for every n other than `g`.
  - `o_rdata` holds the last captured value until the next capture.
- **Reset (asynchronous, effective mid-transaction in any state):**
  - State goes to IDLE and `ptr` goes to 0.
  - All latched and captured registers, including `o_rdata`, go to 0.
  - `o_m_rw`, `o_m_clear`, `o_done`, `o_invalid`, `o_error` and `o_grant` are all 0.
  - `o_wait` still follows its combinational equation.
  - The master shares `i_rst`, so no clear is issued on reset.

## Timing
- A request sampled at edge k in IDLE gives valid `o_m_*` and `o_grant` after edge k.
- `i_m_done` sampled at edge m gives `o_done[g]` high after edge m.
- `i_clear[g]` sampled at edge c gives `o_m_clear` high during (c, c+1].
- After c+1 the arbiter is back in IDLE; the earliest next grant is at edge c+2.
- Fixed overhead per transaction, beyond master latency: one grant cycle plus one clear cycle.
- All outputs except `o_wait` are registered or decoded from registered state; there are no combinational paths from the `i_m_*` inputs to any output.

## Test plan
- **Single write:**
  - Stimulus: req0 writes addr 0x2, size 000, wdata 0xAA; the master asserts done 3 cycles later.
  - Required: `o_m_rw` = 01 and `o_m_addr` = 0x2 one cycle after the request; `o_done[0]` one cycle after `i_m_done`.
  - Then req0 clears: `o_m_clear` is a single-cycle pulse and the arbiter returns to IDLE.
- **Fairness:** req0 (read 0x0) and req1 (write 0x8) hold their requests continuously for 4 transactions. Required grant order is 0, 1, 0, 1, and `o_done[1]` never asserts during req0's transactions.
- **Read capture:** the master returns 0x1122334455667788, then changes `i_m_rdata` while in RESP. `o_rdata` must stay 0x1122334455667788.
- **Illegal command:**
  - Stimulus: req1 sends `rw` = 11; the master responds with invalid = 1.
  - Required: `o_m_rw` = 11, `o_invalid[1]` = 1, `o_invalid[0]` = 0.
  - The next transaction's flags replace these captured values.
- **Abandon and stray clear:** req0 drops `rw` during ISSUE, and req1 pulses `i_clear` during RESP. Required: `o_m_rw` stays latched, `o_done[0]` still asserts, and req1's clear has no effect.
- **Reset mid-ISSUE:** assert `i_rst` asynchronously during ISSUE. Required: all outputs return to their reset values immediately and `ptr` = 0; after release, req1 alone is granted one cycle after it requests.

Source files
------------

// File: rtl/host_bus_arbiter.sv
`default_nettype none
// host_bus_arbiter: round-robin sharing of one simple_axi_master host-bus port among NUM_REQ requesters.
// Revision 1.0
module host_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*3-1:0]      i_size,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  input  logic [NUM_REQ*2-1:0]      i_rw,
  input  logic [NUM_REQ-1:0]        i_clear,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [NUM_REQ-1:0]        o_wait,
  output logic [NUM_REQ-1:0]        o_invalid,
  output logic [NUM_REQ-1:0]        o_error,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [ADDR_W-1:0]         o_m_addr,
  output logic [2:0]                o_m_size,
  output logic [DATA_W-1:0]         o_m_wdata,
  output logic [1:0]                o_m_rw,
  output logic                      o_m_clear,
  input  logic [DATA_W-1:0]         i_m_rdata,
  input  logic                      i_m_wait,
  input  logic                      i_m_done,
  input  logic                      i_m_invalid,
  input  logic                      i_m_error
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, gnt, pick;
  logic               found;
  logic               clear_g;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ADDR_W-1:0]  req_addr;
  logic [2:0]         req_size;
  logic [DATA_W-1:0]  req_wdata;
  logic [1:0]         req_rw;
  logic [DATA_W-1:0]  cap_rdata;
  logic               cap_invalid;
  logic               cap_error;

  // The master's busy flag is informational only; nothing here depends on it.
  logic unused_m_wait;
  assign unused_m_wait = i_m_wait;

  // Round-robin search: first active requester at or after ptr, wrapping.
  always_comb begin : pick_search
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && (i_rw[idx*2 +: 2] != 2'b00)) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  assign clear_g = i_clear[gnt];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)    state_nxt = ISSUE;
      ISSUE:   if (i_m_done) state_nxt = RESP;
      RESP:    if (clear_g)  state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr         <= '0;
      gnt         <= '0;
      req_addr    <= '0;
      req_size    <= '0;
      req_wdata   <= '0;
      req_rw      <= '0;
      cap_rdata   <= '0;
      cap_invalid <= 1'b0;
      cap_error   <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        gnt       <= pick;
        req_addr  <= i_addr[int'(pick)*ADDR_W +: ADDR_W];
        req_size  <= i_size[int'(pick)*3 +: 3];
        req_wdata <= i_wdata[int'(pick)*DATA_W +: DATA_W];
        req_rw    <= i_rw[int'(pick)*2 +: 2];
      end
      if (state == ISSUE && i_m_done) begin
        cap_rdata   <= i_m_rdata;
        cap_invalid <= i_m_invalid;
        cap_error   <= i_m_error;
      end
      if (state == RESP && clear_g) begin
        ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_comb begin
    gnt_onehot      = '0;
    gnt_onehot[gnt] = 1'b1;
  end

  // Requester-facing status; only the granted requester ever sees done/flags.
  assign o_grant   = (state != IDLE) ? gnt_onehot : '0;
  assign o_done    = (state == RESP) ? gnt_onehot : '0;
  assign o_invalid = (state == RESP && cap_invalid) ? gnt_onehot : '0;
  assign o_error   = (state == RESP && cap_error) ? gnt_onehot : '0;
  assign o_rdata   = cap_rdata;

  assign o_m_addr  = req_addr;
  assign o_m_size  = req_size;
  assign o_m_wdata = req_wdata;
  assign o_m_rw    = (state == ISSUE) ? req_rw : 2'b00;
  assign o_m_clear = (state == CLEAR);

  always_comb begin
    o_wait = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      o_wait[n] = (i_rw[n*2 +: 2] != 2'b00) && !((state == RESP) && (int'(gnt) == n));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_bus_arbiter.sv
`default_nettype none
// tb_host_bus_arbiter: directed and randomized checks of host_bus_arbiter against a round-robin reference model.
module tb_host_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] addr;
  logic [N*3-1:0]  size;
  logic [N*DW-1:0] wdata;
  logic [N*2-1:0]  rw;
  logic [N-1:0]    clear;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    done, wt, invalid, error, grant;
  logic [AW-1:0]   m_addr;
  logic [2:0]      m_size;
  logic [DW-1:0]   m_wdata;
  logic [1:0]      m_rw;
  logic            m_clear;
  logic [DW-1:0]   m_rdata;
  logic            m_wait, m_done, m_invalid, m_error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  host_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_size(size), .i_wdata(wdata),
    .i_rw(rw), .i_clear(clear), .o_rdata(rdata), .o_done(done), .o_wait(wt),
    .o_invalid(invalid), .o_error(error), .o_grant(grant), .o_m_addr(m_addr),
    .o_m_size(m_size), .o_m_wdata(m_wdata), .o_m_rw(m_rw), .o_m_clear(m_clear),
    .i_m_rdata(m_rdata), .i_m_wait(m_wait), .i_m_done(m_done),
    .i_m_invalid(m_invalid), .i_m_error(m_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [1:0] r, input logic [AW-1:0] a,
                         input logic [2:0] s, input logic [DW-1:0] d);
    rw[n*2 +: 2]     = r;
    addr[n*AW +: AW] = a;
    size[n*3 +: 3]   = s;
    wdata[n*DW +: DW] = d;
  endtask

  // Reference rule: the next owner is the first pending requester found by
  // walking upward from the owner after the previous one, wrapping around.
  function automatic int model_pick(input logic [N-1:0] pend, input int start);
    for (int k = 0; k < N; k++) begin
      if (pend[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Requester acknowledges and the master drops done on the clear edge.
  task automatic finish_txn(input int g);
    rw[g*2 +: 2] = 2'b00;
    clear[g] = 1'b1;
    tick();
    clear[g] = 1'b0;
    m_done = 1'b0; m_invalid = 1'b0; m_error = 1'b0;
    tick();
    model_ptr = (g + 1) % N;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rw = '0; clear = '0; m_done = 1'b0; m_invalid = 1'b0; m_error = 1'b0;
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr = '0; size = '0; wdata = '0; rw = '0; clear = '0;
    m_rdata = '0; m_wait = 1'b0; m_done = 1'b0; m_invalid = 1'b0; m_error = 1'b0;
    #2;
    rw[1:0] = 2'b01;
    #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (done !== 2'b00) $display("FAIL rst_done: got %b want 00", done); else pass_cnt++;
    total_cnt++; if (m_rw !== 2'b00 || m_clear !== 1'b0) $display("FAIL rst_mrw_mclear: got %b/%b want 00/0", m_rw, m_clear); else pass_cnt++;
    total_cnt++; if (rdata !== '0) $display("FAIL rst_rdata: got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (invalid !== 2'b00 || error !== 2'b00) $display("FAIL rst_flags: got %b/%b want 00/00", invalid, error); else pass_cnt++;
    total_cnt++; if (wt !== 2'b01) $display("FAIL rst_wait: got %b want 01", wt); else pass_cnt++;
    rw = '0;
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_write();
    set_req(0, 2'b01, 32'h2, 3'b000, 64'hAA);
    tick();
    total_cnt++; if (m_rw !== 2'b01) $display("FAIL sw_mrw: got %b want 01", m_rw); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h2 || m_wdata !== 64'hAA || m_size !== 3'b000) $display("FAIL sw_mreq: got %h/%h/%b want 2/aa/000", m_addr, m_wdata, m_size); else pass_cnt++;
    total_cnt++; if (grant !== 2'b01) $display("FAIL sw_grant: got %b want 01", grant); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (done !== 2'b00 || wt !== 2'b01) $display("FAIL sw_pending: got done %b wait %b want 00/01", done, wt); else pass_cnt++;
    m_done = 1'b1;
    tick();
    total_cnt++; if (done !== 2'b01 || wt !== 2'b00) $display("FAIL sw_done: got done %b wait %b want 01/00", done, wt); else pass_cnt++;
    total_cnt++; if (m_rw !== 2'b00) $display("FAIL sw_resp_mrw: got %b want 00", m_rw); else pass_cnt++;
    rw[1:0] = 2'b00;
    clear[0] = 1'b1;
    tick();
    total_cnt++; if (m_clear !== 1'b1 || done !== 2'b00) $display("FAIL sw_clear: got mclear %b done %b want 1/00", m_clear, done); else pass_cnt++;
    clear[0] = 1'b0;
    m_done = 1'b0;
    tick();
    total_cnt++; if (m_clear !== 1'b0 || grant !== 2'b00) $display("FAIL sw_idle: got mclear %b grant %b want 0/00", m_clear, grant); else pass_cnt++;
    model_ptr = 1;
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    set_req(0, 2'b10, 32'h0, 3'd3, 64'h0);
    set_req(1, 2'b01, 32'h8, 3'd3, 64'h5555);
    for (int t = 0; t < 4; t++) begin
      tick();
      g = model_pick(2'b11, model_ptr);
      total_cnt++; if (grant !== onehot(g)) $display("FAIL fair_grant[%0d]: got %b want %b", t, grant, onehot(g)); else pass_cnt++;
      total_cnt++; if (m_addr !== ((g == 1) ? 32'h8 : 32'h0)) $display("FAIL fair_addr[%0d]: got %h", t, m_addr); else pass_cnt++;
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        tick();
        total_cnt++; if (done !== 2'b00) $display("FAIL fair_early_done[%0d]: got %b want 00", t, done); else pass_cnt++;
      end
      m_done = 1'b1;
      tick();
      total_cnt++; if (done !== onehot(g)) $display("FAIL fair_done[%0d]: got %b want %b", t, done, onehot(g)); else pass_cnt++;
      clear[g] = 1'b1;
      tick();
      clear[g] = 1'b0;
      m_done = 1'b0;
      tick();
      total_cnt++; if (grant !== 2'b00) $display("FAIL fair_idle[%0d]: got %b want 00", t, grant); else pass_cnt++;
      model_ptr = (g + 1) % N;
    end
    rw = '0;
    tick();
  endtask

  task automatic test_read_capture();
    set_req(0, 2'b10, 32'h40, 3'd3, 64'h0);
    tick();
    total_cnt++; if (grant !== 2'b01 || m_rw !== 2'b10) $display("FAIL rd_issue: got grant %b mrw %b want 01/10", grant, m_rw); else pass_cnt++;
    m_rdata = 64'h1122334455667788;
    m_done = 1'b1;
    tick();
    total_cnt++; if (rdata !== 64'h1122334455667788) $display("FAIL rd_capture: got %h want 1122334455667788", rdata); else pass_cnt++;
    m_rdata = 64'hDEADBEEFCAFEF00D;
    tick();
    total_cnt++; if (rdata !== 64'h1122334455667788 || done !== 2'b01) $display("FAIL rd_hold: got %h done %b", rdata, done); else pass_cnt++;
    finish_txn(0);
    total_cnt++; if (rdata !== 64'h1122334455667788) $display("FAIL rd_hold_idle: got %h", rdata); else pass_cnt++;
  endtask

  task automatic test_illegal();
    set_req(1, 2'b11, 32'h10, 3'd2, 64'h0);
    tick();
    total_cnt++; if (m_rw !== 2'b11 || grant !== 2'b10) $display("FAIL ill_issue: got mrw %b grant %b want 11/10", m_rw, grant); else pass_cnt++;
    m_invalid = 1'b1;
    m_done = 1'b1;
    tick();
    total_cnt++; if (invalid !== 2'b10 || error !== 2'b00) $display("FAIL ill_flags: got inv %b err %b want 10/00", invalid, error); else pass_cnt++;
    finish_txn(1);
    set_req(0, 2'b01, 32'h20, 3'd1, 64'h77);
    tick();
    m_done = 1'b1;
    m_invalid = 1'b0;
    m_error = 1'b1;
    tick();
    total_cnt++; if (invalid !== 2'b00 || error !== 2'b01) $display("FAIL ill_replace: got inv %b err %b want 00/01", invalid, error); else pass_cnt++;
    finish_txn(0);
  endtask

  task automatic test_abandon();
    set_req(0, 2'b01, 32'h30, 3'd3, 64'hDEAD);
    tick();
    total_cnt++; if (grant !== 2'b01) $display("FAIL ab_grant: got %b want 01", grant); else pass_cnt++;
    set_req(0, 2'b00, 32'h99, 3'd0, 64'h0);
    tick();
    total_cnt++; if (m_rw !== 2'b01 || m_addr !== 32'h30 || m_wdata !== 64'hDEAD) $display("FAIL ab_latched: got %b/%h/%h want 01/30/dead", m_rw, m_addr, m_wdata); else pass_cnt++;
    total_cnt++; if (wt !== 2'b00) $display("FAIL ab_wait: got %b want 00", wt); else pass_cnt++;
    m_done = 1'b1;
    tick();
    total_cnt++; if (done !== 2'b01) $display("FAIL ab_done: got %b want 01", done); else pass_cnt++;
    clear[1] = 1'b1;
    tick();
    total_cnt++; if (done !== 2'b01 || m_clear !== 1'b0) $display("FAIL ab_stray_clear: got done %b mclear %b want 01/0", done, m_clear); else pass_cnt++;
    clear[1] = 1'b0;
    clear[0] = 1'b1;
    tick();
    total_cnt++; if (m_clear !== 1'b1) $display("FAIL ab_clear: got %b want 1", m_clear); else pass_cnt++;
    clear[0] = 1'b0;
    m_done = 1'b0;
    tick();
    model_ptr = 1;
  endtask

  task automatic test_reset_mid_issue();
    set_req(0, 2'b01, 32'h50, 3'd3, 64'h1);
    tick();
    total_cnt++; if (grant !== onehot(model_pick(2'b01, model_ptr))) $display("FAIL rmi_grant: got %b want 01", grant); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (grant !== 2'b00 || m_rw !== 2'b00 || m_clear !== 1'b0) $display("FAIL rmi_async: got grant %b mrw %b mclear %b", grant, m_rw, m_clear); else pass_cnt++;
    total_cnt++; if (rdata !== '0 || done !== 2'b00 || invalid !== 2'b00 || error !== 2'b00) $display("FAIL rmi_regs: got %h/%b/%b/%b", rdata, done, invalid, error); else pass_cnt++;
    total_cnt++; if (wt !== 2'b01) $display("FAIL rmi_wait: got %b want 01", wt); else pass_cnt++;
    m_done = 1'b0;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    set_req(1, 2'b01, 32'h60, 3'd3, 64'h2);
    tick();
    total_cnt++; if (grant !== onehot(model_pick(2'b11, model_ptr))) $display("FAIL rmi_ptr: got %b want 01", grant); else pass_cnt++;
    m_done = 1'b1;
    tick();
    finish_txn(0);
    rw = '0;
    tick();
    set_req(1, 2'b01, 32'h64, 3'd2, 64'h3);
    tick();
    total_cnt++; if (grant !== 2'b10 || m_addr !== 32'h64) $display("FAIL rmi_req1: got grant %b addr %h want 10/64", grant, m_addr); else pass_cnt++;
    m_done = 1'b1;
    tick();
    finish_txn(1);
  endtask

  task automatic test_random();
    logic [N-1:0]  mask;
    logic [1:0]    e_rw [N];
    logic [AW-1:0] e_addr [N];
    logic [2:0]    e_size [N];
    logic [DW-1:0] e_wdata [N];
    logic [DW-1:0] rd;
    logic          inv, err;
    logic [N-1:0]  e_wait;
    int g;
    for (int r = 0; r < 24; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int n = 0; n < N; n++) begin
        e_rw[n]    = mask[n] ? 2'($urandom_range(1, 3)) : 2'b00;
        e_addr[n]  = $urandom;
        e_size[n]  = 3'($urandom_range(0, 7));
        e_wdata[n] = {$urandom, $urandom};
        set_req(n, e_rw[n], e_addr[n], e_size[n], e_wdata[n]);
      end
      tick();
      g = model_pick(mask, model_ptr);
      total_cnt++; if (grant !== onehot(g)) $display("FAIL rnd_grant[%0d]: got %b want %b", r, grant, onehot(g)); else pass_cnt++;
      total_cnt++; if (m_rw !== e_rw[g] || m_addr !== e_addr[g] || m_size !== e_size[g] || m_wdata !== e_wdata[g])
        $display("FAIL rnd_mreq[%0d]: got %b/%h/%b/%h want %b/%h/%b/%h", r, m_rw, m_addr, m_size, m_wdata, e_rw[g], e_addr[g], e_size[g], e_wdata[g]);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) set_req(g, 2'b00, $urandom, 3'd0, {$urandom, $urandom});
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        tick();
        total_cnt++; if (m_rw !== e_rw[g] || m_addr !== e_addr[g] || done !== 2'b00) $display("FAIL rnd_hold[%0d]: got %b/%h done %b", r, m_rw, m_addr, done); else pass_cnt++;
      end
      rd = {$urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      err = 1'($urandom_range(0, 1));
      m_rdata = rd; m_invalid = inv; m_error = err; m_done = 1'b1;
      tick();
      m_rdata = {$urandom, $urandom};
      total_cnt++; if (done !== onehot(g) || rdata !== rd || m_rw !== 2'b00) $display("FAIL rnd_resp[%0d]: got done %b rdata %h mrw %b want %b/%h/00", r, done, rdata, m_rw, onehot(g), rd); else pass_cnt++;
      total_cnt++; if (invalid !== (inv ? onehot(g) : '0) || error !== (err ? onehot(g) : '0)) $display("FAIL rnd_flags[%0d]: got %b/%b inv %b err %b", r, invalid, error, inv, err); else pass_cnt++;
      for (int n = 0; n < N; n++) e_wait[n] = (rw[n*2 +: 2] != 2'b00) && (n != g);
      total_cnt++; if (wt !== e_wait) $display("FAIL rnd_wait[%0d]: got %b want %b", r, wt, e_wait); else pass_cnt++;
      rw[g*2 +: 2] = 2'b00;
      clear[g] = 1'b1;
      tick();
      total_cnt++; if (m_clear !== 1'b1 || grant !== onehot(g)) $display("FAIL rnd_clear[%0d]: got mclear %b grant %b", r, m_clear, grant); else pass_cnt++;
      clear[g] = 1'b0;
      m_done = 1'b0; m_invalid = 1'b0; m_error = 1'b0;
      tick();
      total_cnt++; if (m_clear !== 1'b0 || grant !== 2'b00) $display("FAIL rnd_idle[%0d]: got mclear %b grant %b", r, m_clear, grant); else pass_cnt++;
      model_ptr = (g + 1) % N;
    end
    rw = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_read_capture();
    test_illegal();
    test_abandon();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
